instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder and instruction-memory loader: accepts symbolic instruction requests (operation selector plus register/immediate/target fields) over a valid/ready handshake, packs each into a 32-bit word for the single-cycle CPU's ISA subset, and writes it into instruction memory at consecutive word addresses. It is the write-side counterpart of the CPU's control decoder. Testbenches and boot logic use it to build programs in instruction memory before the CPU is released from reset.

## Interface
- MAX_WORDS, 256, maximum words written per load session (≥1)
- CNT_W, 9, width of count_o (must hold MAX_WORDS)
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-low
- start_i  in  1  begin load session (honoured only in IDLE)
- base_addr_i  in  32  first write address; bits [1:0] forced to 0
- in_valid_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_valid_i & in_ready_o
- op_sel_i  in  4  operation selector (see Operation)
- rs_i / rt_i / rd_i  in  5 each  register fields
- imm_i  in  16  I-type immediate
- target_i  in  26  J-type target
- last_i  in  1  marks final request of session
- imem_we_o  out  1  instruction-memory write strobe
- imem_addr_o  out  32  write address
- imem_data_o  out  32  encoded word
- done_o  out  1  one-cycle pulse, session finished
- err_o  out  1  sticky error, cleared by accepted start_i
- count_o  out  CNT_W  words written in current/last session

## Operation
- FSM: IDLE → LOAD on start_i; LOAD → DONE on accepted request with last_i=1 or when that accept brings count to MAX_WORDS; DONE → IDLE unconditionally next cycle.
- IDLE: start_i latches base_addr_i, clears count_o and err_o. LOAD/DONE: start_i ignored.
- in_ready_o = (state==LOAD); combinational from state only.
- op_sel: 0 ADD funct 100000, 1 SUB 100010, 2 AND 100100, 3 OR 100101, 4 SLT 101010 → {000000,rs,rt,rd,00000,funct}; 5 JR → {000000,rs,15'b0,001000}; 6 ADDI op 001000, 7 SLTI 001010, 8 BEQ 000100, 9 LW 100011, 10 SW 101011 → {op,rs,rt,imm}; 11 J 000010, 12 JAL 000011 → {op,target}.
- op_sel 13–15: word written as 32'h0000_0000 (NOP), err_o set; address still advances.
- Each accept: write registered; address = base + 4·count; count increments; address wraps modulo 2^32.
- MAX_WORDS reached without last_i: session ends, err_o set.

## Timing
- Reset: state IDLE; in_ready_o, imem_we_o, done_o, err_o = 0; imem_addr_o, imem_data_o, count_o = 0.
- Latency: request accepted at edge N → imem_we_o=1 with data/address during cycle N+1 (one cycle, one pulse per accept); count_o updated at N+1.
- start_i sampled at edge S → in_ready_o=1 from cycle S+1.
- Final accept at edge N → state DONE at N+1: done_o=1 coincides with final imem_we_o; in_ready_o=0; IDLE at N+2. start_i in cycle N+1 ignored.
- Back-to-back accepts: one word per cycle, no bubbles.
- Reset mid-session: session aborted at that edge, no further writes; pending write strobe dropped.
- Outputs imem_* and count_o hold last value when imem_we_o=0.

## Structure
- Package mips_isa_pkg: opcode and funct constants (shared with the decoder), op_sel enumeration, FSM state type.
- Sub-module instr_field_encoder: combinational op_sel + fields → {word, illegal}; top holds FSM, address/count registers, output register.

## Test plan
- start base 0x0000_0040; ADD rs=1 rt=2 rd=3 (last) → write 0x0022_1820 @0x40, done_o same cycle, count_o=1.
- Stream ADDI rs=0 rt=8 imm=0x0005, LW rs=29 rt=9 imm=0xFFFC, BEQ rs=8 rt=9 imm=2, JAL target=0x10 (last), back-to-back → 0x2008_0005, 0x8FA9_FFFC, 0x1109_0002, 0x0C00_0010 at 0x0,0x4,0x8,0xC in consecutive cycles.
- op_sel=14 → 0x0000_0000 written, err_o=1 until next start; JR rs=31 → 0x03E0_0008.
- MAX_WORDS=4, five requests without last_i → four writes, done_o, err_o=1, fifth request never accepted.
- base 0xFFFF_FFFC, two words → addresses 0xFFFF_FFFC then 0x0000_0000.
- rst_i low for one cycle after second of four accepts → no further writes, state IDLE, all outputs 0; new start_i works normally.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// ISA constants shared by the CPU control decoder and the instruction encoder,
// plus the request selector codes and the loader FSM state type.
package mips_isa_pkg;

   localparam logic [5:0] OPC_RTYPE = 6'b000000;
   localparam logic [5:0] OPC_ADDI  = 6'b001000;
   localparam logic [5:0] OPC_SLTI  = 6'b001010;
   localparam logic [5:0] OPC_BEQ   = 6'b000100;
   localparam logic [5:0] OPC_LW    = 6'b100011;
   localparam logic [5:0] OPC_SW    = 6'b101011;
   localparam logic [5:0] OPC_J     = 6'b000010;
   localparam logic [5:0] OPC_JAL   = 6'b000011;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_JR  = 6'b001000;

   typedef enum logic [3:0] {
      OPS_ADD  = 4'd0,
      OPS_SUB  = 4'd1,
      OPS_AND  = 4'd2,
      OPS_OR   = 4'd3,
      OPS_SLT  = 4'd4,
      OPS_JR   = 4'd5,
      OPS_ADDI = 4'd6,
      OPS_SLTI = 4'd7,
      OPS_BEQ  = 4'd8,
      OPS_LW   = 4'd9,
      OPS_SW   = 4'd10,
      OPS_J    = 4'd11,
      OPS_JAL  = 4'd12
   } op_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational packer: selector plus operand fields to a 32-bit instruction word.
// Unassigned selectors produce an all-zero word (NOP) and raise illegal_o.
module instr_field_encoder
   import mips_isa_pkg::*;
(
   input  logic [3:0]  op_sel_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [15:0] imm_i,
   input  logic [25:0] target_i,
   output logic [31:0] word_o,
   output logic        illegal_o
);

   always_comb begin
      word_o    = 32'h0000_0000;
      illegal_o = 1'b0;
      case (op_sel_i)
         OPS_ADD:  word_o = r_word(rs_i, rt_i, rd_i, FUNCT_ADD);
         OPS_SUB:  word_o = r_word(rs_i, rt_i, rd_i, FUNCT_SUB);
         OPS_AND:  word_o = r_word(rs_i, rt_i, rd_i, FUNCT_AND);
         OPS_OR:   word_o = r_word(rs_i, rt_i, rd_i, FUNCT_OR);
         OPS_SLT:  word_o = r_word(rs_i, rt_i, rd_i, FUNCT_SLT);
         OPS_JR:   word_o = {OPC_RTYPE, rs_i, 15'b0, FUNCT_JR};
         OPS_ADDI: word_o = i_word(OPC_ADDI, rs_i, rt_i, imm_i);
         OPS_SLTI: word_o = i_word(OPC_SLTI, rs_i, rt_i, imm_i);
         OPS_BEQ:  word_o = i_word(OPC_BEQ, rs_i, rt_i, imm_i);
         OPS_LW:   word_o = i_word(OPC_LW, rs_i, rt_i, imm_i);
         OPS_SW:   word_o = i_word(OPC_SW, rs_i, rt_i, imm_i);
         OPS_J:    word_o = {OPC_J, target_i};
         OPS_JAL:  word_o = {OPC_JAL, target_i};
         default:  illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: accepts encoded requests during a load session and
// writes them at consecutive word addresses, one registered write per accept.
module instr_encoder
   import mips_isa_pkg::*;
#(
   parameter int MAX_WORDS = 256,
   parameter int CNT_W     = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      base_addr_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [3:0]       op_sel_i,
   input  logic [4:0]       rs_i,
   input  logic [4:0]       rt_i,
   input  logic [4:0]       rd_i,
   input  logic [15:0]      imm_i,
   input  logic [25:0]      target_i,
   input  logic             last_i,
   output logic             imem_we_o,
   output logic [31:0]      imem_addr_o,
   output logic [31:0]      imem_data_o,
   output logic             done_o,
   output logic             err_o,
   output logic [CNT_W-1:0] count_o
);

   state_e             state_q, state_d;
   logic [31:0]        base_q, base_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               we_q, we_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        data_q, data_d;
   logic               err_q, err_d;

   logic [31:0]        enc_word;
   logic               enc_illegal;
   logic               accept;
   logic [CNT_W-1:0]   count_inc;
   logic               at_max;

   instr_field_encoder u_field_enc (
      .op_sel_i  (op_sel_i),
      .rs_i      (rs_i),
      .rt_i      (rt_i),
      .rd_i      (rd_i),
      .imm_i     (imm_i),
      .target_i  (target_i),
      .word_o    (enc_word),
      .illegal_o (enc_illegal)
   );

   assign accept    = in_valid_i && (state_q == ST_LOAD);
   assign count_inc = count_q + CNT_W'(1);
   assign at_max    = (count_inc == CNT_W'(MAX_WORDS));

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      count_d = count_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_LOAD;
               base_d  = base_addr_i & 32'hFFFF_FFFC;
               count_d = '0;
               err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               // 32-bit add wraps naturally past the top of the address space
               addr_d  = base_q + (32'(count_q) << 2);
               data_d  = enc_word;
               count_d = count_inc;
               if (enc_illegal || (at_max && !last_i)) begin
                  err_d = 1'b1;
               end
               if (last_i || at_max) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         base_q  <= '0;
         count_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         count_q <= count_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   // DONE lasts exactly one cycle and is entered on the final accept, so it
   // lines up with the final write strobe.
   assign in_ready_o  = (state_q == ST_LOAD);
   assign done_o      = (state_q == ST_DONE);
   assign imem_we_o   = we_q;
   assign imem_addr_o = addr_q;
   assign imem_data_o = data_q;
   assign err_o       = err_q;
   assign count_o     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder (built with MAX_WORDS=4 so the
// session-limit path is reachable with short programs).
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] base_addr_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [3:0]  op_sel_i;
   logic [4:0]  rs_i, rt_i, rd_i;
   logic [15:0] imm_i;
   logic [25:0] target_i;
   logic        last_i;
   logic        imem_we_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_data_o;
   logic        done_o;
   logic        err_o;
   logic [2:0]  count_o;

   always #5 clk = ~clk;

   instr_encoder #(.MAX_WORDS(4), .CNT_W(3)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_sel_i    (op_sel_i),
      .rs_i        (rs_i),
      .rt_i        (rt_i),
      .rd_i        (rd_i),
      .imm_i       (imm_i),
      .target_i    (target_i),
      .last_i      (last_i),
      .imem_we_o   (imem_we_o),
      .imem_addr_o (imem_addr_o),
      .imem_data_o (imem_data_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .count_o     (count_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic        done;
      logic [2:0]  cnt;
      int          cyc;
   } wr_t;

   wr_t wr_q[$];
   int  cyc = 0;
   int  done_cnt = 0;
   int  n_vec = 0;
   int  n_miss = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (imem_we_o) begin
         wr_q.push_back('{imem_addr_o, imem_data_o, done_o, count_o, cyc});
         $display("write addr=%h data=%h done=%0d count=%0d cyc=%0d",
                  imem_addr_o, imem_data_o, done_o, count_o, cyc);
      end
      if (done_o) done_cnt++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_wr(input string tag, input int idx, input logic [31:0] addr,
                           input logic [31:0] data);
      if (idx < wr_q.size()) begin
         check({tag, " addr"}, wr_q[idx].addr, addr);
         check({tag, " data"}, wr_q[idx].data, data);
      end else begin
         check({tag, " missing"}, wr_q.size(), idx + 1);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [31:0] base);
      wr_q.delete();
      done_cnt    = 0;
      start_i     = 1'b1;
      base_addr_i = base;
      @(posedge clk);
      #1;
      start_i     = 1'b0;
   endtask

   task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm,
                          input logic [25:0] tgt, input logic last);
      op_sel_i = op; rs_i = rs; rt_i = rt; rd_i = rd;
      imm_i = imm; target_i = tgt; last_i = last;
      in_valid_i = 1'b1;
   endtask

   // Present one request and hold it until accepted or the cycle budget runs out.
   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                       input logic last, input int budget, output bit acc);
      set_req(op, rs, rt, rd, imm, tgt, last);
      acc = 1'b0;
      for (int i = 0; i < budget && !acc; i++) begin
         @(negedge clk);
         if (in_ready_o) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid_i = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " ready"}, in_ready_o, 0);
      check({tag, " we"},    imem_we_o, 0);
      check({tag, " done"},  done_o, 0);
      check({tag, " err"},   err_o, 0);
      check({tag, " addr"},  imem_addr_o, 0);
      check({tag, " data"},  imem_data_o, 0);
      check({tag, " count"}, count_o, 0);
   endtask

   bit acc;

   initial begin
      rst_i = 1'b0; start_i = 1'b0; base_addr_i = '0; in_valid_i = 1'b0;
      op_sel_i = '0; rs_i = '0; rt_i = '0; rd_i = '0; imm_i = '0; target_i = '0; last_i = 1'b0;
      idle(3);
      check_idle_outputs("reset");
      rst_i = 1'b1;
      idle(1);

      // Single ADD; low address bits of the base are dropped
      start(32'h0000_0043);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 8, acc);
      check("add accept", acc, 1);
      idle(3);
      check("add nwr", wr_q.size(), 1);
      check_wr("add", 0, 32'h0000_0040, 32'h0022_1820);
      if (wr_q.size() > 0) begin
         check("add done_with_we", wr_q[0].done, 1);
         check("add cnt_at_we", wr_q[0].cnt, 1);
      end
      check("add done_pulses", done_cnt, 1);
      check("add ready_after", in_ready_o, 0);
      check("add err", err_o, 0);
      check("add count", count_o, 1);

      // Back-to-back stream of four
      start(32'h0000_0000);
      check("stream ready", in_ready_o, 1);
      send(4'd6,  5'd0,  5'd8, 5'd0, 16'h0005, 26'h0,  1'b0, 8, acc);
      check("stream acc0", acc, 1);
      send(4'd9,  5'd29, 5'd9, 5'd0, 16'hFFFC, 26'h0,  1'b0, 8, acc);
      check("stream acc1", acc, 1);
      send(4'd8,  5'd8,  5'd9, 5'd0, 16'h0002, 26'h0,  1'b0, 8, acc);
      check("stream acc2", acc, 1);
      send(4'd12, 5'd0,  5'd0, 5'd0, 16'h0,    26'h10, 1'b1, 8, acc);
      check("stream acc3", acc, 1);
      idle(3);
      check("stream nwr", wr_q.size(), 4);
      check_wr("addi", 0, 32'h0, 32'h2008_0005);
      check_wr("lw",   1, 32'h4, 32'h8FA9_FFFC);
      check_wr("beq",  2, 32'h8, 32'h1109_0002);
      check_wr("jal",  3, 32'hC, 32'h0C00_0010);
      if (wr_q.size() == 4) begin
         check("stream gap", wr_q[3].cyc - wr_q[0].cyc, 3);
         check("stream done_first", wr_q[0].done, 0);
         check("stream done_last", wr_q[3].done, 1);
      end
      check("stream done_pulses", done_cnt, 1);
      check("stream err", err_o, 0);
      check("stream count", count_o, 4);

      // Illegal selector writes a NOP and sets sticky error
      start(32'h0000_0100);
      send(4'd14, 5'd7,  5'd7, 5'd7, 16'h1234, 26'h0, 1'b0, 8, acc);
      send(4'd7,  5'd1,  5'd2, 5'd0, 16'h8000, 26'h0, 1'b0, 8, acc);
      send(4'd5,  5'd31, 5'd0, 5'd0, 16'h0,    26'h0, 1'b1, 8, acc);
      check("ill acc", acc, 1);
      idle(3);
      check("ill nwr", wr_q.size(), 3);
      check_wr("nop",  0, 32'h100, 32'h0000_0000);
      check_wr("slti", 1, 32'h104, 32'h2822_8000);
      check_wr("jr",   2, 32'h108, 32'h03E0_0008);
      check("ill err", err_o, 1);
      idle(2);
      check("ill err_sticky", err_o, 1);

      // Session limit: four accepted without last, fifth refused
      start(32'h0000_0200);
      check("max err_cleared", err_o, 0);
      check("max count_cleared", count_o, 0);
      send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 8, acc);
      send(4'd2, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 8, acc);
      send(4'd3, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 8, acc);
      send(4'd4, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 8, acc);
      check("max acc4", acc, 1);
      send(4'd0, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 6, acc);
      check("max fifth_refused", acc, 0);
      check("max nwr", wr_q.size(), 4);
      check_wr("sub", 0, 32'h200, 32'h0085_3022);
      check_wr("and", 1, 32'h204, 32'h0085_3024);
      check_wr("or",  2, 32'h208, 32'h0085_3025);
      check_wr("slt", 3, 32'h20C, 32'h0085_302A);
      check("max done_pulses", done_cnt, 1);
      check("max err", err_o, 1);
      check("max count", count_o, 4);

      // Address wrap past the top of memory
      start(32'hFFFF_FFFC);
      send(4'd10, 5'd29, 5'd31, 5'd0, 16'h0004, 26'h0,       1'b0, 8, acc);
      send(4'd11, 5'd0,  5'd0,  5'd0, 16'h0,    26'h3FF_FFFF, 1'b1, 8, acc);
      idle(3);
      check("wrap nwr", wr_q.size(), 2);
      check_wr("sw", 0, 32'hFFFF_FFFC, 32'hAFBF_0004);
      check_wr("j",  1, 32'h0000_0000, 32'h0BFF_FFFF);

      // Reset right after the second accept of a four-word session
      start(32'h0000_0300);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 8, acc);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 8, acc);
      set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
      rst_i = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
      check_idle_outputs("rst");
      idle(3);
      in_valid_i = 1'b0;
      check("rst nwr", wr_q.size(), 2);
      check("rst ready", in_ready_o, 0);
      start(32'h0000_0040);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 8, acc);
      check("rst restart_acc", acc, 1);
      idle(3);
      check("rst restart_nwr", wr_q.size(), 1);
      check_wr("rst restart", 0, 32'h0000_0040, 32'h0022_1820);
      check("rst restart_count", count_o, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
